parity_scan_monitor: RTL and testbench
======================================

# parity_scan_monitor

Parametrised parity generator and monitor for an N_SW-bit switch word. It captures the word on a strobe and registers its even/odd parity bit. A multiplexed seven-segment display shows the parity letter (E/O) and the captured word in hex. The block sits between the board switches and the LED/anode pins and is the next generation of the single-word parity display.

## Interface
- N_SW, 8, data word width (≥1).
- N_LED, 8, segment lines per digit, fixed encoding {a,b,c,d,e,f,g,dp}, bit 7 = a, active-low.
- N_LED_AN, 4, number of digits (≥2).
- SCAN_DIV, 50000, clock cycles each digit is held (≥1).
- E, 8'b01100001, segment code for letter E.
- O, 8'b00000011, segment code for letter O.
- clk_i  input  1  system clock.
- rst_ni  input  1  reset; asynchronous, active-low.
- sw_i  input  N_SW  data word.
- strobe_i  input  1  capture request, synchronous to clk_i.
- odd_mode_i  input  1  0 = even-parity generation, 1 = odd-parity generation.
- parity_o  output  1  registered generated parity bit of the captured word.
- led_o  output  N_LED  segment drive for the active digit.
- led_an_o  output  N_LED_AN  one-cold anode select.

## Operation
- Capture: on a rising edge with strobe_i=1, word_q<=sw_i. On the same edge, parity_o <= ^sw_i ^ odd_mode_i, and odd_q <= ^sw_i. odd_mode_i is sampled only on the strobe. A held strobe recaptures every cycle.
- Display content:
  - Digit 0 shows E when odd_q=0 and O when odd_q=1.
  - Digit k (1..N_LED_AN-1) shows hex nibble k-1 of word_q. The top nibble is zero-extended when N_SW is not a multiple of 4.
  - Digits with no nibble (k-1 ≥ ceil(N_SW/4)) show BLANK (all ones).
  - Nibbles beyond N_LED_AN-1 are not shown.
- Scan FSM: the prescaler counts 0..SCAN_DIV-1. On the terminal count it wraps to 0 and the digit index advances (N_LED_AN-1 wraps to 0). led_an_o has bit [index] low and all others high.
- led_o and led_an_o are registered from the same index, so they never disagree for a cycle.
- Reset values:
  - word_q=0, odd_q=0, parity_o=0, prescaler=0, index=0.
  - led_an_o = all ones except bit 0 low.
  - led_o = E.
- Reset mid-scan or mid-capture aborts the operation, and all state returns to the reset values immediately (asynchronously).

## Timing
- Capture to parity_o: 1 cycle, visible after the strobing edge.
- Capture to display: the affected digit shows the new value from the next cycle in which its anode is active. Worst case is N_LED_AN·SCAN_DIV cycles.
- Digit period is exactly SCAN_DIV cycles. The full frame is N_LED_AN·SCAN_DIV cycles.
- When a strobe coincides with an index advance, the output registered on that edge uses the old word. The new word appears no later than 1 cycle after.
- A strobe in the first cycle after reset deassertion is captured normally.

## Configuration
- PARITY_SCAN_MONITOR_CHECK_EN defined:
  - Adds input par_i (1), output err_o (1), and output err_cnt_o (8).
  - par_i is captured with the word.
  - err_o <= (par_i != generated parity) on each strobe and holds until the next strobe.
  - err_cnt_o increments on each mismatching strobe and saturates at 255.
  - Both outputs reset to 0.
- Not defined: none of these ports or registers exist, and the behaviour is otherwise identical.

## Structure
- Shared package parity_pkg holds:
  - the segment-encoding constants: the 16-entry hex table, BLANK, and default E/O;
  - the nibble-count helper (ceil(N_SW/4));
  - the checker counter width.
- One sub-module, seg_scan_ctrl, contains the prescaler, the digit index, and anode generation. It outputs the index; the top level selects the segment code.
- Hex table entries 0..F: 00000011, 10011111, 00100101, 00001101, 10011001, 01001001, 01000001, 00011111, 00000001, 00001001, 00010001, 11000001, 01100011, 10000101, 01100001, 01110001.

## Test plan
- Reset with SCAN_DIV=4 -> parity_o=0, led_an_o=1110, led_o=01100001 (E); after 4 cycles led_an_o=1101, led_o=00000011 (hex 0).
- sw_i=8'hA5, strobe, odd_mode_i=0 -> parity_o=0, digit0=E, digit1=01001001 (5), digit2=00010001 (A), digit3=11111111. Repeat with odd_mode_i=1 -> parity_o=1, digit0 still E.
- sw_i=8'h07, strobe, odd_mode_i=0 -> parity_o=1, digit0=00000011 (O), digit1=00011111 (7), digit2=00000011 (0).
- Anode scan with SCAN_DIV=4 -> sequence 1110, 1101, 1011, 0111, 1110, each held exactly 4 cycles; led_o always matches the active digit.
- rst_ni pulsed low during digit 2 after capturing 8'hFF -> all outputs return to reset values without waiting for a clock edge; the next strobe of 8'h01 gives parity_o=1 one cycle later.
- With PARITY_SCAN_MONITOR_CHECK_EN: sw_i=8'h03, par_i=1, even mode -> err_o=1, err_cnt_o=1. After 300 mismatching strobes -> err_cnt_o=255. Then a matching strobe (par_i=0) -> err_o=0, err_cnt_o=255.

Source files
------------

// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - segment encodings, nibble-count helper and checker width
package parity_pkg;

  localparam logic [7:0] SEG_BLANK = 8'b1111_1111;
  localparam logic [7:0] SEG_E     = 8'b0110_0001;
  localparam logic [7:0] SEG_O     = 8'b0000_0011;

  localparam int ERR_CNT_W = 8;

  // Active-low {a,b,c,d,e,f,g,dp} code for one hex nibble
  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'b0000_0011;
      4'h1: seg = 8'b1001_1111;
      4'h2: seg = 8'b0010_0101;
      4'h3: seg = 8'b0000_1101;
      4'h4: seg = 8'b1001_1001;
      4'h5: seg = 8'b0100_1001;
      4'h6: seg = 8'b0100_0001;
      4'h7: seg = 8'b0001_1111;
      4'h8: seg = 8'b0000_0001;
      4'h9: seg = 8'b0000_1001;
      4'hA: seg = 8'b0001_0001;
      4'hB: seg = 8'b1100_0001;
      4'hC: seg = 8'b0110_0011;
      4'hD: seg = 8'b1000_0101;
      4'hE: seg = 8'b0110_0001;
      default: seg = 8'b0111_0001;
    endcase
    return seg;
  endfunction

  // Number of hex digits needed to show an n_bits wide word
  function automatic int nibble_count(input int n_bits);
    return (n_bits + 3) / 4;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - digit prescaler, digit index and one-cold anode register
module seg_scan_ctrl #(
  parameter int N_LED_AN = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  output logic [$clog2(N_LED_AN)-1:0] o_idx,
  output logic [N_LED_AN-1:0]         o_led_an
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = $clog2(N_LED_AN);

  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [N_LED_AN-1:0] r_an;
  logic                w_tick;

  // Next prescaler count and digit index; index advances on the terminal count
  always_comb begin
    w_tick    = (r_cnt == CNT_W'(SCAN_DIV - 1));
    w_cnt_nxt = w_tick ? '0 : r_cnt + 1'b1;
    w_idx_nxt = r_idx;
    if (w_tick) begin
      w_idx_nxt = (r_idx == IDX_W'(N_LED_AN - 1)) ? '0 : r_idx + 1'b1;
    end
  end

  // Scan state; the anode is registered from the next index so it lines up with led_o
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_an  <= ~N_LED_AN'(1);
    end else begin
      r_cnt <= w_cnt_nxt;
      r_idx <= w_idx_nxt;
      r_an  <= ~(N_LED_AN'(1) << w_idx_nxt);
    end
  end

  assign o_idx    = w_idx_nxt;
  assign o_led_an = r_an;

endmodule

// File: rtl/parity_scan_monitor.sv
// rtl/parity_scan_monitor.sv - strobed parity generator with multiplexed 7-seg display; option PARITY_SCAN_MONITOR_CHECK_EN
module parity_scan_monitor
  import parity_pkg::*;
#(
  parameter int         N_SW     = 8,
  parameter int         N_LED    = 8,
  parameter int         N_LED_AN = 4,
  parameter int         SCAN_DIV = 50000,
  parameter logic [7:0] E        = SEG_E,
  parameter logic [7:0] O        = SEG_O
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N_SW-1:0]      sw_i,
  input  logic                 strobe_i,
  input  logic                 odd_mode_i,
  output logic                 parity_o,
  output logic [N_LED-1:0]     led_o,
  output logic [N_LED_AN-1:0]  led_an_o
`ifdef PARITY_SCAN_MONITOR_CHECK_EN
  ,
  input  logic                 par_i,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
`endif
);

  localparam int NIB_CNT = nibble_count(N_SW);
  localparam int IDX_W   = $clog2(N_LED_AN);

  logic [N_SW-1:0]      r_word;
  logic                 r_odd;
  logic                 r_parity;
  logic [N_LED-1:0]     r_led;
  logic [4*NIB_CNT-1:0] w_word_ext;
  logic [IDX_W-1:0]     w_idx;
  logic [N_LED-1:0]     w_digit_seg [N_LED_AN];

  // Capture the word and its parity on each strobe
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_word   <= '0;
      r_odd    <= 1'b0;
      r_parity <= 1'b0;
    end else if (strobe_i) begin
      r_word   <= sw_i;
      r_odd    <= ^sw_i;
      r_parity <= (^sw_i) ^ odd_mode_i;
    end
  end

  assign w_word_ext     = (4*NIB_CNT)'(r_word);
  assign w_digit_seg[0] = r_odd ? N_LED'(O) : N_LED'(E);

  for (genvar k = 1; k < N_LED_AN; k++) begin : g_digit
    if (k - 1 < NIB_CNT) begin : g_nib
      assign w_digit_seg[k] = N_LED'(hex_seg(w_word_ext[4*(k-1) +: 4]));
    end else begin : g_blank
      assign w_digit_seg[k] = N_LED'(SEG_BLANK);
    end
  end

  seg_scan_ctrl #(
    .N_LED_AN (N_LED_AN),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .i_clk    (clk_i),
    .i_rst_n  (rst_ni),
    .o_idx    (w_idx),
    .o_led_an (led_an_o)
  );

  // Segment register loaded every cycle from the same index as the anode
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_led <= N_LED'(E);
    end else begin
      r_led <= w_digit_seg[w_idx];
    end
  end

  assign parity_o = r_parity;
  assign led_o    = r_led;

`ifdef PARITY_SCAN_MONITOR_CHECK_EN
  logic                 r_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 w_mismatch;

  assign w_mismatch = (par_i != ((^sw_i) ^ odd_mode_i));

  // Flag a supplied/generated parity mismatch per strobe and count them, saturating
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if (strobe_i) begin
      r_err <= w_mismatch;
      if (w_mismatch && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign err_o     = r_err;
  assign err_cnt_o = r_err_cnt;
`endif

endmodule

// File: tb/tb_parity_scan_monitor.sv
// tb/tb_parity_scan_monitor.sv - directed self-checking bench for parity_scan_monitor
module tb_parity_scan_monitor;

  localparam logic [7:0] S_E  = 8'b0110_0001;
  localparam logic [7:0] S_O  = 8'b0000_0011;
  localparam logic [7:0] S_0  = 8'b0000_0011;
  localparam logic [7:0] S_5  = 8'b0100_1001;
  localparam logic [7:0] S_7  = 8'b0001_1111;
  localparam logic [7:0] S_A  = 8'b0001_0001;
  localparam logic [7:0] S_BL = 8'b1111_1111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sw;
  logic       strobe;
  logic       odd_mode;
  logic       parity;
  logic [7:0] led;
  logic [3:0] led_an;
  logic       par;
`ifdef PARITY_SCAN_MONITOR_CHECK_EN
  logic       err;
  logic [7:0] err_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] frame [4];

  always #5 clk = ~clk;

  parity_scan_monitor #(
    .N_SW     (8),
    .N_LED    (8),
    .N_LED_AN (4),
    .SCAN_DIV (4)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .sw_i       (sw),
    .strobe_i   (strobe),
    .odd_mode_i (odd_mode),
    .parity_o   (parity),
    .led_o      (led),
    .led_an_o   (led_an)
`ifdef PARITY_SCAN_MONITOR_CHECK_EN
    ,
    .par_i      (par),
    .err_o      (err),
    .err_cnt_o  (err_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b", tag, obs, exp);
  endtask

  task automatic do_strobe(input logic [7:0] w, input logic m, input logic p);
    @(negedge clk);
    sw = w; odd_mode = m; par = p; strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic read_frame();
    for (int d = 0; d < 4; d++) frame[d] = 8'hxx;
    @(negedge clk);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) if (led_an[d] == 1'b0) frame[d] = led;
    end
  endtask

  initial begin
    int         k;
    int         len;
    logic [3:0] prev;
    logic [3:0] exp_an  [4];
    logic [7:0] exp_seg [4];
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_seg = '{S_O, S_7, S_0, S_BL};

    rst_n = 1'b0; sw = '0; strobe = 1'b0; odd_mode = 1'b0; par = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_parity", parity, 1'b0);
    check("rst_an", led_an, 4'b1110);
    check("rst_led", led, S_E);
`ifdef PARITY_SCAN_MONITOR_CHECK_EN
    check("rst_err", err, 1'b0);
    check("rst_err_cnt", err_cnt, 8'd0);
`endif
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("hold_digit0_an", led_an, 4'b1110);
    @(negedge clk);
    check("adv_digit1_an", led_an, 4'b1101);
    check("adv_digit1_led", led, S_0);

    do_strobe(8'hA5, 1'b0, 1'b0);
    check("a5_even_parity", parity, 1'b0);
    read_frame();
    check("a5_digit0", frame[0], S_E);
    check("a5_digit1", frame[1], S_5);
    check("a5_digit2", frame[2], S_A);
    check("a5_digit3", frame[3], S_BL);

    do_strobe(8'hA5, 1'b1, 1'b1);
    check("a5_odd_parity", parity, 1'b1);
    read_frame();
    check("a5_odd_digit0", frame[0], S_E);

    do_strobe(8'h07, 1'b0, 1'b1);
    check("07_parity", parity, 1'b1);
    read_frame();
    check("07_digit0", frame[0], S_O);
    check("07_digit1", frame[1], S_7);
    check("07_digit2", frame[2], S_0);
    check("07_digit3", frame[3], S_BL);

    k = 0;
    prev = led_an;
    @(negedge clk);
    while (!(prev != 4'b1110 && led_an == 4'b1110) && k < 40) begin
      prev = led_an;
      @(negedge clk);
      k++;
    end
    check("scan_sync", led_an, 4'b1110);
    for (int i = 0; i < 4; i++) begin
      check("scan_an", led_an, exp_an[i]);
      len = 0;
      while (led_an == exp_an[i] && len < 10) begin
        check("scan_led", led, exp_seg[i]);
        len++;
        @(negedge clk);
      end
      check("scan_len", len, 4);
    end
    check("scan_wrap_an", led_an, 4'b1110);

    do_strobe(8'hFF, 1'b1, 1'b1);
    check("ff_odd_parity", parity, 1'b1);
    k = 0;
    while (led_an !== 4'b1011 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("wait_digit2", led_an, 4'b1011);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_parity", parity, 1'b0);
    check("async_rst_an", led_an, 4'b1110);
    check("async_rst_led", led, S_E);
    #1 rst_n = 1'b1;
    sw = 8'h01; odd_mode = 1'b0; par = 1'b1; strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    check("post_rst_parity", parity, 1'b1);
    check("post_rst_an", led_an, 4'b1110);

`ifdef PARITY_SCAN_MONITOR_CHECK_EN
    do_reset();
    check("chk_rst_cnt", err_cnt, 8'd0);
    do_strobe(8'h03, 1'b0, 1'b1);
    check("chk_err_first", err, 1'b1);
    check("chk_cnt_first", err_cnt, 8'd1);
    @(negedge clk);
    sw = 8'h03; odd_mode = 1'b0; par = 1'b1; strobe = 1'b1;
    repeat (299) @(negedge clk);
    strobe = 1'b0;
    check("chk_cnt_sat", err_cnt, 8'd255);
    check("chk_err_held", err, 1'b1);
    do_strobe(8'h03, 1'b0, 1'b0);
    check("chk_err_match", err, 1'b0);
    check("chk_cnt_match", err_cnt, 8'd255);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
